// File: rtl/video_switch_ctrl_pkg.sv
// Shared video definitions for the 40/80-column source switch controller:
// controller states and the default timing constants.
package video_switch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_WAIT_VS,
    ST_RST,
    ST_RESYNC,
    ST_SETTLE
  } vsw_state_t;

  localparam int DEF_RST_LEN       = 16;
  localparam int DEF_SETTLE_FRAMES = 2;
  localparam int DEF_TO_BITS       = 21;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_switch_ctrl.sv
// Video source switch controller: switches the mux select on a vsync boundary,
// resets and waits for the downstream sync generator to relock, and mutes video meanwhile.
module video_switch_ctrl
  import video_switch_ctrl_pkg::*;
#(
  parameter int RST_LEN       = DEF_RST_LEN,
  parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
  parameter int TO_BITS       = DEF_TO_BITS
) (
  input  logic clk32,
  input  logic reset,
  input  logic pause,
  input  logic sel_req,
  input  logic vsync_in,
  input  logic sync_valid,
  output logic sel,
  output logic sync_reset,
  output logic mute,
  output logic busy,
  output logic timeout
);

  localparam int CYC_W = cnt_width(RST_LEN);
  localparam int FRM_W = cnt_width(SETTLE_FRAMES);

  vsw_state_t         state_q, state_d;
  logic               vs_q;
  logic               target_q, target_d;
  logic               init_q, init_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [TO_BITS-1:0] to_q, to_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic               sel_d, sync_reset_d, mute_d, timeout_d;
  logic               vs_edge, to_full, cyc_last, frm_last, relatch;
  logic               go_rst, rst_target;

  assign vs_edge  = vsync_in & ~vs_q;
  assign to_full  = &to_q;
  assign cyc_last = (cyc_q == CYC_W'(RST_LEN - 1));
  assign frm_last = (frm_q == FRM_W'(SETTLE_FRAMES - 1));
  assign relatch  = (sel_req != sel);
  assign busy     = (state_q != ST_ACTIVE);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    init_d       = init_q;
    cyc_d        = cyc_q;
    to_d         = to_q;
    frm_d        = frm_q;
    sel_d        = sel;
    sync_reset_d = sync_reset;
    mute_d       = mute;
    timeout_d    = timeout;
    go_rst       = 1'b0;
    rst_target   = sel_req;

    case (state_q)
      ST_ACTIVE: begin
        if (relatch) begin
          target_d = sel_req;
          to_d     = '0;
          state_d  = ST_WAIT_VS;
        end
      end

      // A vsync edge wins over a simultaneous timeout; both lead to the reset anyway.
      ST_WAIT_VS: begin
        if (!relatch) begin
          to_d    = '0;
          state_d = ST_ACTIVE;
        end else if (vs_edge || to_full) begin
          go_rst     = 1'b1;
          rst_target = target_q;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      // The first cycle out of reset adopts sel_req without restarting the pulse.
      ST_RST: begin
        if (!init_q && relatch) begin
          go_rst = 1'b1;
        end else begin
          if (init_q) begin
            init_d   = 1'b0;
            target_d = sel_req;
            sel_d    = sel_req;
          end
          if (cyc_last) begin
            sync_reset_d = 1'b0;
            to_d         = '0;
            state_d      = ST_RESYNC;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end

      ST_RESYNC: begin
        if (relatch) begin
          go_rst = 1'b1;
        end else if (sync_valid) begin
          frm_d   = '0;
          to_d    = '0;
          state_d = ST_SETTLE;
        end else if (to_full) begin
          to_d      = '0;
          timeout_d = 1'b1;
          mute_d    = 1'b0;
          state_d   = ST_ACTIVE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (relatch) begin
          go_rst = 1'b1;
        end else if (!sync_valid) begin
          to_d    = '0;
          state_d = ST_RESYNC;
        end else if (vs_edge) begin
          if (frm_last) begin
            mute_d    = 1'b0;
            timeout_d = 1'b0;
            to_d      = '0;
            state_d   = ST_ACTIVE;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end
      end

      default: begin
        go_rst = 1'b1;
      end
    endcase

    // Every path into RST (re)starts a full sync_reset pulse with video muted.
    if (go_rst) begin
      state_d      = ST_RST;
      target_d     = rst_target;
      sel_d        = rst_target;
      mute_d       = 1'b1;
      sync_reset_d = 1'b1;
      cyc_d        = '0;
      to_d         = '0;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q    <= ST_RST;
      vs_q       <= 1'b0;
      target_q   <= 1'b0;
      init_q     <= 1'b1;
      cyc_q      <= '0;
      to_q       <= '0;
      frm_q      <= '0;
      sel        <= 1'b0;
      sync_reset <= 1'b1;
      mute       <= 1'b1;
      timeout    <= 1'b0;
    end else if (!pause) begin
      state_q    <= state_d;
      vs_q       <= vsync_in;
      target_q   <= target_d;
      init_q     <= init_d;
      cyc_q      <= cyc_d;
      to_q       <= to_d;
      frm_q      <= frm_d;
      sel        <= sel_d;
      sync_reset <= sync_reset_d;
      mute       <= mute_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_video_switch_ctrl.sv
// Scoreboard bench for video_switch_ctrl: scenarios predict each output change
// (value and cycle) from the switching rules; a monitor matches them as they occur.
module tb_video_switch_ctrl;

  localparam int RST_LEN       = 16;
  localparam int SETTLE_FRAMES = 2;
  localparam int TO_BITS       = 13;
  localparam int TO_CYCLES     = 1 << TO_BITS;
  localparam logic [4:0] RESET_VEC = 5'b01110;

  logic clk32 = 1'b0;
  logic reset, pause, sel_req, vsync_in, sync_valid;
  logic sel, sync_reset, mute, busy, timeout;

  typedef struct {
    logic [4:0] vec;
    int         at;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [4:0] mon_cur;
  logic [4:0] prev_vec = RESET_VEC;
  logic [4:0] m_vec;
  logic       m_sel, m_to;
  logic       mon_on = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  video_switch_ctrl #(
    .RST_LEN(RST_LEN),
    .SETTLE_FRAMES(SETTLE_FRAMES),
    .TO_BITS(TO_BITS)
  ) dut (
    .clk32(clk32),
    .reset(reset),
    .pause(pause),
    .sel_req(sel_req),
    .vsync_in(vsync_in),
    .sync_valid(sync_valid),
    .sel(sel),
    .sync_reset(sync_reset),
    .mute(mute),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  function automatic logic [4:0] vec_of(input logic s, input logic sr, input logic mu,
                                        input logic bz, input logic to);
    return {s, sr, mu, bz, to};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input logic [4:0] v, input int at);
    exp_t e;
    e.vec = v;
    e.at  = at;
    e.tag = tag;
    exp_q.push_back(e);
    m_vec = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check_output("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Each change of the output vector must match the oldest prediction.
  always @(negedge clk32) begin
    if (mon_on) begin
      mon_cur = {sel, sync_reset, mute, busy, timeout};
      if (mon_cur !== prev_vec) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_change: got %b, want %b (cycle %0d)", mon_cur, prev_vec, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output({mon_e.tag, "_vec"}, 32'(mon_cur), 32'(mon_e.vec));
          check_output({mon_e.tag, "_cycle"}, cyc, mon_e.at);
        end
        prev_vec = mon_cur;
      end
    end
  end

  task automatic vs_pulse();
    tick($urandom_range(1, 40));
    vsync_in = 1'b1;
    tick($urandom_range(1, 4));
    vsync_in = 1'b0;
  endtask

  // From RESYNC: valid rises, optionally drops once mid-settle, then frames complete.
  task automatic settle_normal(input int valid_delay, input logic drop);
    tick(valid_delay);
    sync_valid = 1'b1;
    if (drop) begin
      repeat (SETTLE_FRAMES - 1) vs_pulse();
      sync_valid = 1'b0;
      tick($urandom_range(1, 100));
      sync_valid = 1'b1;
    end
    for (int f = 0; f < SETTLE_FRAMES; f++) begin
      tick($urandom_range(1, 40));
      vsync_in = 1'b1;
      if (f == SETTLE_FRAMES - 1) begin
        m_to = 1'b0;
        push_exp("settle_done", vec_of(m_sel, 1'b0, 1'b0, 1'b0, 1'b0), cyc + 1);
      end
      tick($urandom_range(1, 4));
      vsync_in = 1'b0;
    end
    tick(2);
  endtask

  // Called on the cycle RST was entered; mode 0 plain, 1 paused for p cycles, 2 re-latched.
  task automatic run_rst(input int mode, input int p);
    int entry;
    int o;
    int pl;
    entry = cyc;
    if (mode == 2) begin
      o = $urandom_range(1, 12);
      tick(o);
      m_sel   = ~m_sel;
      sel_req = m_sel;
      push_exp("rst_relatch", vec_of(m_sel, 1'b1, 1'b1, 1'b1, m_to), cyc + 1);
      tick(1);
      entry = cyc;
    end
    pl = (mode == 1) ? p : 0;
    push_exp("sr_drop", vec_of(m_sel, 1'b0, 1'b1, 1'b1, m_to), entry + RST_LEN + pl);
    if (mode == 1) begin
      o = $urandom_range(1, 12);
      tick(o);
      pause = 1'b1;
      tick(pl);
      pause = 1'b0;
    end
    tick(entry + RST_LEN + pl - cyc);
  endtask

  // end_mode: 0 settle, 1 timeout in RESYNC, 2 flip during SETTLE, 3 stop frozen in SETTLE.
  task automatic apply_stimulus(input int vs_gap, input int rst_mode, input int pause_len,
                                input int end_mode, input int valid_delay);
    sel_req = ~m_sel;
    push_exp("enter_wait", vec_of(m_sel, 1'b0, 1'b0, 1'b1, m_to), cyc + 1);
    tick(vs_gap);
    sync_valid = 1'b0;
    vsync_in   = 1'b1;
    m_sel      = ~m_sel;
    push_exp("rst_entry", vec_of(m_sel, 1'b1, 1'b1, 1'b1, m_to), cyc + 1);
    tick(1);
    vsync_in = 1'b0;
    run_rst(rst_mode, pause_len);
    case (end_mode)
      1: begin
        m_to = 1'b1;
        push_exp("timeout", vec_of(m_sel, 1'b0, 1'b0, 1'b0, 1'b1), cyc + TO_CYCLES);
        tick(TO_CYCLES);
      end
      2: begin
        tick($urandom_range(1, 50));
        sync_valid = 1'b1;
        if (SETTLE_FRAMES > 1) vs_pulse();
        tick($urandom_range(1, 20));
        m_sel      = ~m_sel;
        sel_req    = m_sel;
        sync_valid = 1'b0;
        push_exp("settle_flip", vec_of(m_sel, 1'b1, 1'b1, 1'b1, m_to), cyc + 1);
        tick(1);
        run_rst(0, 0);
        settle_normal(valid_delay, 1'b0);
      end
      3: begin
        tick(3);
        sync_valid = 1'b1;
        tick(5);
        pause = 1'b1;
        tick(3);
      end
      default: settle_normal(valid_delay, 1'($urandom_range(0, 1)));
    endcase
    drain();
  endtask

  task automatic do_abort(input int g);
    sel_req = ~m_sel;
    push_exp("abort_wait", vec_of(m_sel, 1'b0, 1'b0, 1'b1, m_to), cyc + 1);
    tick(g);
    sel_req = m_sel;
    push_exp("abort_back", vec_of(m_sel, 1'b0, 1'b0, 1'b0, m_to), cyc + 1);
    tick(3);
    drain();
  endtask

  task automatic apply_reset(input logic req, input int hold, input logic hold_pause,
                             input int valid_delay);
    if (mon_on && m_vec != RESET_VEC) push_exp("reset_vec", RESET_VEC, cyc + 1);
    reset      = 1'b1;
    pause      = hold_pause;
    sel_req    = req;
    sync_valid = 1'b0;
    vsync_in   = 1'b0;
    tick(hold);
    check_output("reset_state", 32'({sel, sync_reset, mute, busy, timeout}), 32'(RESET_VEC));
    mon_on = 1'b1;
    reset  = 1'b0;
    pause  = 1'b0;
    m_sel  = req;
    m_to   = 1'b0;
    if (req) push_exp("pwr_sel", vec_of(1'b1, 1'b1, 1'b1, 1'b1, 1'b0), cyc + 1);
    push_exp("pwr_sr_drop", vec_of(req, 1'b0, 1'b1, 1'b1, 1'b0), cyc + RST_LEN);
    tick(RST_LEN);
    settle_normal(valid_delay, 1'b0);
    drain();
    check_output("pwr_busy", 32'(busy), 32'(1'b0));
  endtask

  initial begin
    reset      = 1'b1;
    pause      = 1'b0;
    sel_req    = 1'b0;
    vsync_in   = 1'b0;
    sync_valid = 1'b0;
    m_vec      = RESET_VEC;
    m_sel      = 1'b0;
    m_to       = 1'b0;

    apply_reset(1'b1, 3, 1'b0, 100);
    apply_stimulus(100, 0, 0, 0, 40);
    apply_stimulus(5000, 0, 0, 0, 40);
    do_abort(120);
    apply_stimulus(200, 0, 0, 1, 0);
    apply_stimulus(60, 0, 0, 0, 30);
    apply_stimulus(30, 1, 50, 0, 20);
    apply_stimulus(30, 0, 0, 2, 20);
    apply_stimulus(30, 2, 0, 0, 20);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_abort($urandom_range(1, 300));
      else
        apply_stimulus($urandom_range(1, 400), $urandom_range(0, 2), $urandom_range(1, 30),
                       ($urandom_range(0, 3) == 0) ? 2 : 0, $urandom_range(0, 150));
    end
    apply_stimulus(40, 0, 0, 3, 0);
    apply_reset(1'($urandom_range(0, 1)), 4, 1'b1, 50);
    apply_stimulus($urandom_range(1, 200), 0, 0, 0, 30);

    check_output("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: got cycle %0d, want completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/video_switch_ctrl.md
VIDEO_SWITCH_CTRL -- requirements
Module: video_switch_ctrl

Interface
REQ-001 SHALL have parameter RST_LEN, default 16, sync_reset pulse length in clk32 cycles.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 2, vsync rising edges after valid before unmute.
REQ-003 SHALL have parameter TO_BITS, default 21, timeout counter width (2^TO_BITS-1 cycles).
REQ-004 SHALL have one clock and a synchronous, active-high reset. Already decided, stated exactly: one clock; reset is synchronous and active-high.
REQ-005 clk32  input  1  system clock (32 MHz domain).
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 pause  input  1  freeze: state, counters and outputs held.
REQ-008 sel_req  input  1  requested source, 0 = VIC-II 40-col, 1 = VDC 80-col.
REQ-009 vsync_in  input  1  vsync_out of the downstream sync generator.
REQ-010 sync_valid  input  1  valid of the downstream sync generator.
REQ-011 sel  output  1  registered video mux select.
REQ-012 sync_reset  output  1  reset to the sync generator.
REQ-013 mute  output  1  force black / blank video out.
REQ-014 busy  output  1  high in every state except ACTIVE.
REQ-015 timeout  output  1  sticky, last switch ended on timeout.

Function
REQ-016 States SHALL be ACTIVE, WAIT_VS, RST, RESYNC, SETTLE.
REQ-017 Vsync edge SHALL be vsync_in=1 with registered vsync_in=0; the register updates only when !pause.
REQ-018 ACTIVE: mute=0, sync_reset=0. When sel_req != sel: latch target=sel_req, clear timeout counter, go to WAIT_VS next cycle.
REQ-019 WAIT_VS: if sel_req == sel, abort to ACTIVE with sel unchanged. On vsync edge or timeout counter all-ones, go to RST.
REQ-020 RST entry (registered, same edge as the transition): mute=1, sel=target, sync_reset=1, cycle counter=0.
REQ-021 RST SHALL hold sync_reset high for exactly RST_LEN cycles, then drop it and go to RESYNC with the timeout counter cleared.
REQ-022 RESYNC: sync_valid=1 SHALL go to SETTLE with frame counter=0. Timeout all-ones SHALL go to ACTIVE, set timeout=1, mute=0.
REQ-023 SETTLE: each vsync edge SHALL increment the frame counter. At SETTLE_FRAMES SHALL go to ACTIVE, mute=0, timeout=0. sync_valid falling SHALL return to RESYNC.
REQ-024 sel_req != sel during RST/RESYNC/SETTLE SHALL re-latch target and re-enter RST without waiting for vsync (already muted).
REQ-025 The timeout counter SHALL count only in WAIT_VS/RESYNC, saturate at all-ones, and be cleared on every state entry.
REQ-026 A vsync edge and a timeout in the same cycle SHALL be treated as the vsync edge (WAIT_VS) or as the timeout (RESYNC).
REQ-027 sel SHALL change only on entry to RST; mute SHALL be 1 whenever sel changes.
REQ-028 pause=1 SHALL suspend all state, counter and output updates, including the sync_reset count.

Reset
REQ-029 Reset SHALL set state=RST, cycle counter=0, sel=0, mute=1, sync_reset=1, busy=1, timeout=0, vsync register=0, target=0.
REQ-030 On the first cycle after reset, target SHALL load sel_req and sel SHALL follow it. The power-on sequence then completes as RST->RESYNC->SETTLE->ACTIVE.
REQ-031 Reset asserted mid-sequence SHALL override every state, including pause.

Structure
REQ-032 The state enum and default parameter constants SHALL live in the shared video package.
REQ-033 There SHALL be no sub-modules; edge detect and counters are inline.

Verification
REQ-034 Reset, sel_req=1, valid rises 100 cycles after sync_reset falls, two vsync edges -> sync_reset high exactly 16 cycles, sel=1, mute=0 after the 2nd edge, busy=0.
REQ-035 In ACTIVE sel=0, sel_req->1, vsync edge 5000 cycles later -> sel stays 0 and mute=0 until the edge; sel=1 and mute=1 the next cycle.
REQ-036 sel_req toggles 0->1->0 inside WAIT_VS before vsync -> return to ACTIVE, sel=0, mute never asserted, sync_reset never asserted.
REQ-037 sync_valid held 0 after a switch -> ACTIVE after 2^21 RESYNC cycles, timeout=1, mute=0; the next good switch clears timeout.
REQ-038 sel_req flips during SETTLE -> immediate RST (no vsync wait), sel=new value, a fresh 16-cycle sync_reset.
REQ-039 pause=1 for 50 cycles during RST -> total sync_reset high time = 16 + 50 cycles, state unchanged.
